// File: rtl/ram_arbiter_pkg.sv
// Shared types and default geometry for the RAM access controller and the ram block.
package ram_ctrl_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side and RAM-side signals of the two-port RAM arbiter.
interface ram_arbiter_if
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;

  logic              busy;
  logic              grant_id;

  logic [ADDR_W-1:0] ram_address;
  logic              ram_writeOn;
  logic [DATA_W-1:0] ram_data_in;
  logic [DATA_W-1:0] ram_data_out;

  // master is the surrounding system (requesters plus the ram read port)
  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_data_out,
    input  ack0, rdata0, ack1, rdata1, busy, grant_id,
    input  ram_address, ram_writeOn, ram_data_in
  );

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_data_out,
    output ack0, rdata0, ack1, rdata1, busy, grant_id,
    output ram_address, ram_writeOn, ram_data_in
  );

endinterface

// File: rtl/ram_arbiter_rr_pick2.sv
// Two-way round-robin winner select; on a tie the requester not served last wins.
module rr_pick2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic lastGrant_i,
  output logic winner_o,
  output logic valid_o
);

  always_comb begin
    valid_o  = req0_i | req1_i;
    winner_o = (req0_i & req1_i) ? ~lastGrant_i : req1_i;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Serialises two requesters onto one asynchronous RAM port with a
// SETUP/ACCESS/DONE sequence so the write strobe always sees stable address and data.
module ram_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input logic          clk,
  input logic          reset,
  ram_arbiter_if.slave bus
);

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              lastGrant_q, lastGrant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              busy_q, busy_d;
  logic              writeOn_q, writeOn_d;

  logic pickId;
  logic pickValid;

  rr_pick2 u_pick (
    .req0_i      (bus.req0),
    .req1_i      (bus.req1),
    .lastGrant_i (lastGrant_q),
    .winner_o    (pickId),
    .valid_o     (pickValid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      lastGrant_q <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      busy_q      <= 1'b0;
      writeOn_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      lastGrant_q <= lastGrant_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      busy_q      <= busy_d;
      writeOn_q   <= writeOn_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    lastGrant_d = lastGrant_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;

    unique case (state_q)
      IDLE: begin
        if (pickValid) begin
          state_d = SETUP;
          grant_d = pickId;
          we_d    = pickId ? bus.we1    : bus.we0;
          addr_d  = pickId ? bus.addr1  : bus.addr0;
          wdata_d = pickId ? bus.wdata1 : bus.wdata0;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        state_d = DONE;
        if (!we_q) begin
          if (grant_q) rdata1_d = bus.ram_data_out;
          else         rdata0_d = bus.ram_data_out;
        end
      end
      DONE: begin
        state_d     = IDLE;
        lastGrant_d = grant_q;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so that every one of them leaves a flop.
    busy_d    = (state_d != IDLE);
    writeOn_d = (state_d == ACCESS) && we_d;
    ack0_d    = (state_d == DONE) && !grant_d;
    ack1_d    = (state_d == DONE) && grant_d;
  end

  assign bus.ack0        = ack0_q;
  assign bus.ack1        = ack1_q;
  assign bus.rdata0      = rdata0_q;
  assign bus.rdata1      = rdata1_q;
  assign bus.busy        = busy_q;
  assign bus.grant_id    = grant_q;
  assign bus.ram_address = addr_q;
  assign bus.ram_data_in = wdata_q;
  assign bus.ram_writeOn = writeOn_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 32x32 RAM on the RAM side.
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  ram_arbiter_if bus ();

  ram_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [32];

  assign bus.ram_data_out = mem[bus.ram_address];

  // RAM model: cleared on reset so reads of untouched words are deterministic
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (bus.ram_writeOn) begin
      mem[bus.ram_address] <= bus.ram_data_in;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset;
    reset      = 1'b1;
    bus.req0   = 1'b0;
    bus.we0    = 1'b0;
    bus.addr0  = '0;
    bus.wdata0 = '0;
    bus.req1   = 1'b0;
    bus.we1    = 1'b0;
    bus.addr1  = '0;
    bus.wdata1 = '0;
    tick;
    tick;
    reset = 1'b0;
    tick;
  endtask

  // Issues one access and returns the tick on which ack appeared (-1 on timeout)
  task automatic runAccess(input bit id, input bit we, input logic [4:0] a,
                           input logic [31:0] d, output int ackAt,
                           output int wrAt, output int wrCount);
    ackAt   = -1;
    wrAt    = -1;
    wrCount = 0;
    if (id == 1'b0) begin
      bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; bus.req0 = 1'b1;
    end else begin
      bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; bus.req1 = 1'b1;
    end
    for (int c = 1; c <= 12; c++) begin
      tick;
      if (bus.ram_writeOn) begin
        wrCount++;
        if (wrAt < 0) wrAt = c;
      end
      if ((id == 1'b0 && bus.ack0) || (id == 1'b1 && bus.ack1)) begin
        ackAt = c;
        break;
      end
    end
    if (id == 1'b0) bus.req0 = 1'b0;
    else            bus.req1 = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    applyReset;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.grant_id !== 1'b0) begin bad++; $display("[TB] FAIL reset_grant got=%b exp=0", bus.grant_id); end
    total++; if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0) begin bad++; $display("[TB] FAIL reset_ack got=%b%b exp=00", bus.ack0, bus.ack1); end
    total++; if (bus.rdata0 !== 32'h0 || bus.rdata1 !== 32'h0) begin bad++; $display("[TB] FAIL reset_rdata got=%h/%h exp=0/0", bus.rdata0, bus.rdata1); end
    total++; if (bus.ram_address !== 5'd0) begin bad++; $display("[TB] FAIL reset_addr got=%0d exp=0", bus.ram_address); end
    total++; if (bus.ram_data_in !== 32'h0) begin bad++; $display("[TB] FAIL reset_din got=%h exp=0", bus.ram_data_in); end
    total++; if (bus.ram_writeOn !== 1'b0) begin bad++; $display("[TB] FAIL reset_writeOn got=%b exp=0", bus.ram_writeOn); end
  endtask

  task automatic test_write_read;
    int ackAt, wrAt, wrCount;
    runAccess(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, ackAt, wrAt, wrCount);
    total++; if (ackAt !== 3) begin bad++; $display("[TB] FAIL wr_ack_latency got=%0d exp=3", ackAt); end
    total++; if (wrAt !== 2) begin bad++; $display("[TB] FAIL wr_strobe_cycle got=%0d exp=2", wrAt); end
    total++; if (wrCount !== 1) begin bad++; $display("[TB] FAIL wr_strobe_count got=%0d exp=1", wrCount); end
    runAccess(1'b0, 1'b0, 5'd5, 32'h0, ackAt, wrAt, wrCount);
    total++; if (ackAt !== 3) begin bad++; $display("[TB] FAIL rd_ack_latency got=%0d exp=3", ackAt); end
    total++; if (wrCount !== 0) begin bad++; $display("[TB] FAIL rd_strobe_count got=%0d exp=0", wrCount); end
    total++; if (bus.rdata0 !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL rd_data0 got=%h exp=deadbeef", bus.rdata0); end
  endtask

  task automatic test_simultaneous;
    int ack0At, ack1At;
    applyReset;
    ack0At = -1;
    ack1At = -1;
    bus.we0 = 1'b1; bus.addr0 = 5'd3; bus.wdata0 = 32'h1; bus.req0 = 1'b1;
    bus.we1 = 1'b0; bus.addr1 = 5'd3; bus.wdata1 = 32'h0; bus.req1 = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick;
      if (bus.ack0 && ack0At < 0) begin ack0At = c; bus.req0 = 1'b0; end
      if (bus.ack1 && ack1At < 0) begin ack1At = c; bus.req1 = 1'b0; break; end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    tick;
    total++; if (ack0At !== 3) begin bad++; $display("[TB] FAIL sim_ack0 got=%0d exp=3", ack0At); end
    total++; if (ack1At !== 7) begin bad++; $display("[TB] FAIL sim_ack1 got=%0d exp=7", ack1At); end
    total++; if (bus.rdata1 !== 32'h1) begin bad++; $display("[TB] FAIL sim_rdata1 got=%h exp=00000001", bus.rdata1); end
  endtask

  task automatic test_fairness;
    int n;
    n = 0;
    bus.we0 = 1'b0; bus.addr0 = 5'd3; bus.req0 = 1'b1;
    bus.we1 = 1'b0; bus.addr1 = 5'd3; bus.req1 = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick;
      if (bus.ack0 || bus.ack1) begin
        total++;
        if (bus.ack0 === bus.ack1 || bus.ack1 !== n[0] || c !== 4 * n + 3) begin
          bad++;
          $display("[TB] FAIL fair_grant%0d got=ack%b%b@%0d exp=ack1=%0d@%0d", n, bus.ack0, bus.ack1, c, n % 2, 4 * n + 3);
        end
        n++;
        if (n == 6) begin
          bus.req0 = 1'b0;
          bus.req1 = 1'b0;
          break;
        end
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    tick;
    total++; if (n !== 6) begin bad++; $display("[TB] FAIL fair_count got=%0d exp=6", n); end
    total++; if (bus.rdata0 !== 32'h1 || bus.rdata1 !== 32'h1) begin bad++; $display("[TB] FAIL fair_rdata got=%h/%h exp=1/1", bus.rdata0, bus.rdata1); end
  endtask

  task automatic test_isolation;
    int ackAt, wrAt, wrCount;
    bit sawAck0, done;
    runAccess(1'b0, 1'b1, 5'd10, 32'hAAAA5555, ackAt, wrAt, wrCount);
    runAccess(1'b0, 1'b0, 5'd10, 32'h0, ackAt, wrAt, wrCount);
    runAccess(1'b1, 1'b1, 5'd0, 32'h12345678, ackAt, wrAt, wrCount);
    total++; if (bus.rdata0 !== 32'hAAAA5555) begin bad++; $display("[TB] FAIL iso_setup got=%h exp=aaaa5555", bus.rdata0); end
    sawAck0 = 1'b0;
    done = 1'b0;
    bus.we1 = 1'b0; bus.addr1 = 5'd0; bus.req1 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick;
      if (bus.ack0) sawAck0 = 1'b1;
      if (bus.ack1) begin done = 1'b1; break; end
    end
    bus.req1 = 1'b0;
    tick;
    if (bus.ack0) sawAck0 = 1'b1;
    total++; if (!done) begin bad++; $display("[TB] FAIL iso_ack1 got=timeout exp=ack"); end
    total++; if (sawAck0) begin bad++; $display("[TB] FAIL iso_ack0 got=1 exp=0"); end
    total++; if (bus.rdata0 !== 32'hAAAA5555) begin bad++; $display("[TB] FAIL iso_rdata0 got=%h exp=aaaa5555", bus.rdata0); end
    total++; if (bus.rdata1 !== 32'h12345678) begin bad++; $display("[TB] FAIL iso_rdata1 got=%h exp=12345678", bus.rdata1); end
  endtask

  task automatic test_reset_mid_write;
    int ackAt, wrAt, wrCount;
    bus.we0 = 1'b1; bus.addr0 = 5'd7; bus.wdata0 = 32'h55; bus.req0 = 1'b1;
    tick;
    tick;
    total++; if (bus.ram_writeOn !== 1'b1) begin bad++; $display("[TB] FAIL rst_pre_writeOn got=%b exp=1", bus.ram_writeOn); end
    #3;
    reset = 1'b1;
    #1;
    total++; if (bus.ram_writeOn !== 1'b0) begin bad++; $display("[TB] FAIL rst_writeOn got=%b exp=0", bus.ram_writeOn); end
    total++; if (bus.busy !== 1'b0 || bus.ram_address !== 5'd0 || bus.ram_data_in !== 32'h0) begin
      bad++; $display("[TB] FAIL rst_outputs got=busy%b addr%0d din%h exp=busy0 addr0 din0", bus.busy, bus.ram_address, bus.ram_data_in);
    end
    bus.req0 = 1'b0;
    tick;
    reset = 1'b0;
    tick;
    tick;
    total++; if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0) begin bad++; $display("[TB] FAIL rst_no_ack got=%b%b exp=00", bus.ack0, bus.ack1); end
    total++; if (bus.rdata0 !== 32'h0) begin bad++; $display("[TB] FAIL rst_rdata0 got=%h exp=0", bus.rdata0); end
    runAccess(1'b1, 1'b1, 5'd7, 32'h77, ackAt, wrAt, wrCount);
    total++; if (ackAt !== 3) begin bad++; $display("[TB] FAIL rst_recover_ack got=%0d exp=3", ackAt); end
    runAccess(1'b0, 1'b0, 5'd7, 32'h0, ackAt, wrAt, wrCount);
    total++; if (bus.rdata0 !== 32'h77) begin bad++; $display("[TB] FAIL rst_recover_data got=%h exp=77", bus.rdata0); end
  endtask

  task automatic test_wrap;
    int ackAt, wrAt, wrCount;
    runAccess(1'b1, 1'b1, 5'd31, 32'hCAFE0031, ackAt, wrAt, wrCount);
    total++; if (bus.ram_address !== 5'd31) begin bad++; $display("[TB] FAIL wrap_addr31 got=%0d exp=31", bus.ram_address); end
    runAccess(1'b1, 1'b1, 5'd0, 32'h0BAD0000, ackAt, wrAt, wrCount);
    runAccess(1'b0, 1'b0, 5'd31, 32'h0, ackAt, wrAt, wrCount);
    total++; if (bus.rdata0 !== 32'hCAFE0031) begin bad++; $display("[TB] FAIL wrap_rd31 got=%h exp=cafe0031", bus.rdata0); end
    runAccess(1'b1, 1'b0, 5'd0, 32'h0, ackAt, wrAt, wrCount);
    total++; if (bus.rdata1 !== 32'h0BAD0000) begin bad++; $display("[TB] FAIL wrap_rd0 got=%h exp=0bad0000", bus.rdata1); end
    total++; if (bus.ram_address !== 5'd0) begin bad++; $display("[TB] FAIL wrap_addr0 got=%0d exp=0", bus.ram_address); end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_simultaneous;
    test_fairness;
    test_isolation;
    test_reset_mid_write;
    test_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
